// File: rtl/calc_res_fifo.sv
// calc_res_fifo: show-ahead result FIFO between one ray-march lane and a MipVram calc_res port.
// Define CALC_RES_FIFO_MAX_MERGE_EN to coalesce repeated (x,y) samples into the tail entry (max density).
module calc_res_fifo #(
    parameter  int DEPTH = 16,
    parameter  int X_W   = 10,
    parameter  int Y_W   = 10,
    parameter  int D_W   = 8,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [X_W-1:0]   io_in_pos_x,
    input  logic [Y_W-1:0]   io_in_pos_y,
    input  logic [D_W-1:0]   io_in_density,
    output logic             io_data_valid,
    input  logic             io_rden,
    output logic [X_W-1:0]   io_screen_pos_x,
    output logic [Y_W-1:0]   io_screen_pos_y,
    output logic [D_W-1:0]   io_density,
    output logic [LVL_W-1:0] io_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [D_W-1:0] d;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             in_ready_q;
    logic             data_valid;
    logic             accept;
    logic             push;
    logic             pop;
    entry_t           head;

    assign data_valid = (count_q != '0);
    assign pop        = io_rden & data_valid;
    assign accept     = io_in_valid & io_in_ready;

`ifdef CALC_RES_FIFO_MAX_MERGE_EN
    logic [X_W-1:0]   last_x_q;
    logic [Y_W-1:0]   last_y_q;
    logic             last_vld_q;
    logic             tail_match;
    logic             merge;
    logic [PTR_W-1:0] tail_ptr;

    // The tail only leaves this cycle when it is also the head being popped.
    assign tail_match = last_vld_q && data_valid
                        && (io_in_pos_x == last_x_q) && (io_in_pos_y == last_y_q)
                        && !(pop && count_q == LVL_W'(1));
    assign tail_ptr    = wr_ptr_q - PTR_W'(1);
    assign merge       = accept & tail_match;
    assign push        = accept & ~tail_match;
    assign io_in_ready = in_ready_q | tail_match;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_x_q   <= '0;
            last_y_q   <= '0;
            last_vld_q <= 1'b0;
        end else if (push) begin
            last_x_q   <= io_in_pos_x;
            last_y_q   <= io_in_pos_y;
            last_vld_q <= 1'b1;
        end else if (count_d == '0) begin
            last_vld_q <= 1'b0;
        end
    end
`else
    assign push        = accept;
    assign io_in_ready = in_ready_q;
`endif

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + LVL_W'(1);
        else if (!push && pop) count_d = count_q - LVL_W'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= (count_d != FULL);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= '{x: io_in_pos_x, y: io_in_pos_y, d: io_in_density};
`ifdef CALC_RES_FIFO_MAX_MERGE_EN
        if (merge && (io_in_density > mem_q[tail_ptr].d)) mem_q[tail_ptr].d <= io_in_density;
`endif
    end

    assign head            = data_valid ? mem_q[rd_ptr_q] : '0;
    assign io_data_valid   = data_valid;
    assign io_screen_pos_x = head.x;
    assign io_screen_pos_y = head.y;
    assign io_density      = head.d;
    assign io_level        = count_q;

    // Overflow and underflow are prevented by in_ready and the data_valid gate on rden.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(push && !pop && count_q == FULL));
            assert (!(pop && count_q == '0));
        end
    end

endmodule

// File: tb/tb_calc_res_fifo.sv
// tb_calc_res_fifo: randomized bench for calc_res_fifo against a queue-based reference model.
// Follows CALC_RES_FIFO_MAX_MERGE_EN so the model matches whichever build is compiled.
module tb_calc_res_fifo;

    localparam int DEPTH = 16;

    typedef struct {
        bit [9:0] x;
        bit [9:0] y;
        bit [7:0] d;
    } ent_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       io_in_valid = 1'b0;
    logic       io_in_ready;
    logic [9:0] io_in_pos_x = '0;
    logic [9:0] io_in_pos_y = '0;
    logic [7:0] io_in_density = '0;
    logic       io_data_valid;
    logic       io_rden = 1'b0;
    logic [9:0] io_screen_pos_x;
    logic [9:0] io_screen_pos_y;
    logic [7:0] io_density;
    logic [4:0] io_level;

    calc_res_fifo dut (
        .clock           (clock),
        .reset           (reset),
        .io_in_valid     (io_in_valid),
        .io_in_ready     (io_in_ready),
        .io_in_pos_x     (io_in_pos_x),
        .io_in_pos_y     (io_in_pos_y),
        .io_in_density   (io_in_density),
        .io_data_valid   (io_data_valid),
        .io_rden         (io_rden),
        .io_screen_pos_x (io_screen_pos_x),
        .io_screen_pos_y (io_screen_pos_y),
        .io_density      (io_density),
        .io_level        (io_level)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: FIFO contents as a queue, plus the registered ready and last-written key.
    ent_t     q[$];
    bit       ready_m = 1'b0;
    bit       lvld = 1'b0;
    bit [9:0] lx, ly;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: drive inputs, compare against the model, clock once, update the model.
    task automatic cycle(input bit v, input bit [9:0] x, input bit [9:0] y, input bit [7:0] d,
                         input bit rd);
        bit   mt, acc, pp;
        ent_t h, t;
        io_in_valid   = v;
        io_in_pos_x   = x;
        io_in_pos_y   = y;
        io_in_density = d;
        io_rden       = rd;
        #1;
        mt = 1'b0;
`ifdef CALC_RES_FIFO_MAX_MERGE_EN
        mt = lvld && (q.size() != 0) && (x == lx) && (y == ly) && !(rd && q.size() == 1);
`endif
        h = (q.size() != 0) ? q[0] : '{x: 10'd0, y: 10'd0, d: 8'd0};
        check("in_ready",   32'(io_in_ready),     32'(ready_m | mt));
        check("data_valid", 32'(io_data_valid),   32'(q.size() != 0));
        check("level",      32'(io_level),        32'(q.size()));
        check("head_x",     32'(io_screen_pos_x), 32'(h.x));
        check("head_y",     32'(io_screen_pos_y), 32'(h.y));
        check("head_d",     32'(io_density),      32'(h.d));
        pp  = rd && (q.size() != 0);
        acc = v && (ready_m || mt);
        @(posedge clock);
        if (acc && mt) begin
            t = q[q.size() - 1];
            if (d > t.d) t.d = d;
            q[q.size() - 1] = t;
        end
        if (pp) void'(q.pop_front());
        if (acc && !mt) begin
            q.push_back('{x: x, y: y, d: d});
            lx   = x;
            ly   = y;
            lvld = 1'b1;
        end
        if (q.size() == 0) lvld = 1'b0;
        ready_m = (q.size() != DEPTH);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 10'd0, 10'd0, 8'd0, 1'b0);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 10'd0, 10'd0, 8'd0, 1'b1);
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b1, 10'(i + 200), 10'($urandom), 8'($urandom), 1'b0);
    endtask

    initial begin
        // 1. Reset then idle
        @(negedge clock);
        @(negedge clock);
        check("rst_valid", 32'(io_data_valid), 32'd0);
        check("rst_level", 32'(io_level),      32'd0);
        check("rst_ready", 32'(io_in_ready),   32'd0);
        check("rst_head",  32'(io_density),    32'd0);
        reset = 1'b0;
        idle(1);
        check("ready_after_release", 32'(io_in_ready), 32'd1);
        idle(2);

        // 2. Single push, show-ahead head, then pop
        cycle(1'b1, 10'd3, 10'd5, 8'h40, 1'b0);
        check("t2_valid", 32'(io_data_valid),   32'd1);
        check("t2_x",     32'(io_screen_pos_x), 32'd3);
        check("t2_y",     32'(io_screen_pos_y), 32'd5);
        check("t2_d",     32'(io_density),      32'h40);
        cycle(1'b0, 10'd0, 10'd0, 8'd0, 1'b1);
        check("t2_pop_valid", 32'(io_data_valid), 32'd0);

        // 3. Fill to full (17th refused), then drain across the pointer wrap
        push_rand(17);
        check("t3_level_full", 32'(io_level),    32'd16);
        check("t3_ready_full", 32'(io_in_ready), 32'd0);
        cycle(1'b1, 10'd999, 10'd1, 8'd1, 1'b1);
        check("t3_ready_after_pop", 32'(io_in_ready), 32'd1);
        check("t3_level_after_pop", 32'(io_level),    32'd15);
        pop_n(16);
        check("t3_level_empty", 32'(io_level), 32'd0);

        // 4. Steady push+pop at level 8
        push_rand(8);
        for (int i = 0; i < 100; i++)
            cycle(1'b1, 10'(i), 10'($urandom), 8'($urandom), 1'b1);
        check("t4_level", 32'(io_level), 32'd8);
        pop_n(8);

        // 5. Asynchronous reset mid-stream at level 10
        push_rand(10);
        check("t5_level_before", 32'(io_level), 32'd10);
        #2 reset = 1'b1;
        #1;
        check("t5_async_valid", 32'(io_data_valid), 32'd0);
        check("t5_async_level", 32'(io_level),      32'd0);
        check("t5_async_ready", 32'(io_in_ready),   32'd0);
        q.delete();
        lvld    = 1'b0;
        ready_m = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        cycle(1'b1, 10'd1, 10'd1, 8'd1, 1'b0);
        check("t5_ignored_before_ready", 32'(io_level), 32'd0);

        // 6. Repeated (x,y): coalesced when the merge build is compiled
        cycle(1'b1, 10'd7, 10'd7, 8'h10, 1'b0);
        cycle(1'b1, 10'd7, 10'd7, 8'h30, 1'b0);
        cycle(1'b1, 10'd7, 10'd7, 8'h20, 1'b0);
`ifdef CALC_RES_FIFO_MAX_MERGE_EN
        check("t6_level",  32'(io_level),   32'd1);
        check("t6_density", 32'(io_density), 32'h30);
`else
        check("t6_level",  32'(io_level),   32'd3);
        check("t6_density", 32'(io_density), 32'h10);
`endif
        pop_n(3);

        // Random mixed traffic on a small key space so repeats are frequent
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, 10'($urandom_range(0, 2)),
                  10'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 2) == 0);
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 1) == 0, 10'($urandom_range(0, 2)),
                  10'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) != 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
